// File: rtl/template_peak_finder.sv
// -----------------------------------------------------------------------------
// template_peak_finder
//
// Follows the raster position of the template-correlation stream. For each
// frame it keeps the strongest correlation value that meets the threshold and
// lies inside the valid window (x >= X_OFF, y >= Y_OFF). At end of frame it
// reports the window-centre coordinates and score over a valid/ready handshake.
//
// Optional feature macro: TEMPLATE_PEAK_HITCOUNT_EN
//   When defined, adds hit_count, a saturating count of candidate pixels in
//   the frame. It is loaded and held together with the other results.
//
// Ports
//   clock        : system clock, rising edge
//   reset_n      : synchronous active-low reset
//   corr_in      : 16-bit correlation value of the current pixel
//   pix_valid    : corr_in is valid; the raster advances only on these cycles
//   sof          : start of frame (qualified by pix_valid), marks pixel (0,0)
//   threshold    : minimum accepted score, latched when sof is accepted
//   result_valid : frame result is available
//   result_ready : consumer accepts the result
//   peak_x/peak_y: window-centre coordinates of the peak
//   peak_val     : peak correlation value
//   found        : at least one pixel met the threshold
//   overrun      : sticky, set when a pending result was overwritten
//   hit_count    : (optional) number of candidates in the frame, saturating
// -----------------------------------------------------------------------------
module template_peak_finder #(
    parameter int IMG_W = 768,
    parameter int IMG_H = 576,
    parameter int X_OFF = 16,
    parameter int Y_OFF = 16,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [15:0]   corr_in,
    input  logic          pix_valid,
    input  logic          sof,
    input  logic [15:0]   threshold,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [XW-1:0] peak_x,
    output logic [YW-1:0] peak_y,
    output logic [15:0]   peak_val,
    output logic          found,
    output logic          overrun
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
    ,
    output logic [XW+YW-1:0] hit_count
`endif
);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_OFF_C = XW'(X_OFF);
    localparam logic [YW-1:0] Y_OFF_C = YW'(Y_OFF);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [15:0]   thr_reg;
    logic [15:0]   best_val;
    logic [XW-1:0] best_x;
    logic [YW-1:0] best_y;
    logic          hit;
    logic          done_q;     // last pixel accepted last cycle: load results

    // Effective view of the pixel being accepted. A sof pixel is evaluated at
    // (0,0) against the new threshold, with best/hit state already cleared.
    logic          start;
    logic          accept;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [15:0]   cur_thr;
    logic          hit_eff;
    logic [15:0]   best_eff;
    logic          cand;
    logic          take;
    logic          last_pix;

`ifdef TEMPLATE_PEAK_HITCOUNT_EN
    logic [XW+YW-1:0] hit_cnt;
    logic [XW+YW-1:0] hit_base;
`endif

    // NOTE: every signal gets a default at the top of always_comb, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        start    = pix_valid && sof;
        accept   = pix_valid && (sof || state == ACTIVE);
        cur_x    = start ? '0 : x_cnt;
        cur_y    = start ? '0 : y_cnt;
        cur_thr  = start ? threshold : thr_reg;
        hit_eff  = start ? 1'b0 : hit;
        best_eff = start ? 16'd0 : best_val;
        cand     = accept && (cur_x >= X_OFF_C) && (cur_y >= Y_OFF_C)
                   && (corr_in >= cur_thr);
        // First candidate always seeds the best; later ones need a strictly
        // larger value, so the earliest pixel wins ties.
        take     = cand && (!hit_eff || corr_in > best_eff);
        last_pix = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
        hit_base = start ? '0 : hit_cnt;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            thr_reg      <= '0;
            best_val     <= '0;
            best_x       <= '0;
            best_y       <= '0;
            hit          <= 1'b0;
            done_q       <= 1'b0;
            result_valid <= 1'b0;
            peak_x       <= '0;
            peak_y       <= '0;
            peak_val     <= '0;
            found        <= 1'b0;
            overrun      <= 1'b0;
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
            hit_cnt      <= '0;
            hit_count    <= '0;
`endif
        end else begin
            done_q <= last_pix;

            if (accept) begin
                thr_reg <= cur_thr;
                if (last_pix) begin
                    state <= IDLE;
                    x_cnt <= '0;
                    y_cnt <= '0;
                end else begin
                    state <= ACTIVE;
                    if (cur_x == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= cur_y + 1'b1;
                    end else begin
                        x_cnt <= cur_x + 1'b1;
                        y_cnt <= cur_y;
                    end
                end

                if (take) begin
                    best_val <= corr_in;
                    best_x   <= cur_x - X_OFF_C;
                    best_y   <= cur_y - Y_OFF_C;
                end else if (start) begin
                    best_val <= '0;
                    best_x   <= '0;
                    best_y   <= '0;
                end
                hit <= hit_eff || cand;

`ifdef TEMPLATE_PEAK_HITCOUNT_EN
                if (cand && hit_base != '1)
                    hit_cnt <= hit_base + 1'b1;
                else
                    hit_cnt <= hit_base;
`endif
            end

            // Result stage: a load wins over a same-cycle handshake, and
            // overwriting an unaccepted result is flagged permanently.
            if (done_q) begin
                result_valid <= 1'b1;
                found        <= hit;
                peak_x       <= hit ? best_x   : '0;
                peak_y       <= hit ? best_y   : '0;
                peak_val     <= hit ? best_val : '0;
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
                hit_count    <= hit_cnt;
`endif
                if (result_valid && !result_ready)
                    overrun <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_template_peak_finder.sv
// -----------------------------------------------------------------------------
// Testbench for template_peak_finder with a small 8x6 image.
// Stimulus pushes the reference result of each completed frame into a queue;
// a monitor pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_template_peak_finder;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int X_OFF = 2;
    localparam int Y_OFF = 2;
    localparam int XW    = 3;
    localparam int YW    = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [15:0]   corr_in;
    logic          pix_valid;
    logic          sof;
    logic [15:0]   threshold;
    logic          result_valid;
    logic          result_ready;
    logic [XW-1:0] peak_x;
    logic [YW-1:0] peak_y;
    logic [15:0]   peak_val;
    logic          found;
    logic          overrun;
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
    logic [XW+YW-1:0] hit_count;
`endif

    template_peak_finder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
        .XW(XW), .YW(YW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .corr_in      (corr_in),
        .pix_valid    (pix_valid),
        .sof          (sof),
        .threshold    (threshold),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .peak_x       (peak_x),
        .peak_y       (peak_y),
        .peak_val     (peak_val),
        .found        (found),
        .overrun      (overrun)
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
        ,
        .hit_count    (hit_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int val;
        int found;
        int hits;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] frame_mem [IMG_H][IMG_W];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Reference: collect candidates, take the maximum, report the first
    // raster position holding that maximum.
    function automatic res_t model(input int thr);
        res_t r;
        int   max_v;
        r = '{default: 0};
        max_v = -1;
        for (int y = Y_OFF; y < IMG_H; y++)
            for (int x = X_OFF; x < IMG_W; x++)
                if (int'(frame_mem[y][x]) >= thr) begin
                    r.hits++;
                    if (int'(frame_mem[y][x]) > max_v) max_v = int'(frame_mem[y][x]);
                end
        if (r.hits > (1 << (XW + YW)) - 1) r.hits = (1 << (XW + YW)) - 1;
        if (max_v >= 0) begin
            r.found = 1;
            r.val   = max_v;
            for (int i = NPIX - 1; i >= 0; i--)
                if (i % IMG_W >= X_OFF && i / IMG_W >= Y_OFF &&
                    int'(frame_mem[i / IMG_W][i % IMG_W]) == max_v) begin
                    r.x = i % IMG_W - X_OFF;
                    r.y = i / IMG_W - Y_OFF;
                end
        end
        return r;
    endfunction

    task automatic fill_zero();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) frame_mem[y][x] = 16'd0;
    endtask

    task automatic fill_random(input int max_v);
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                frame_mem[y][x] = 16'($urandom_range(0, max_v));
    endtask

    // Idle cycle with junk on the data lines, including an unqualified sof.
    task automatic idle_cycle();
        pix_valid = 1'b0;
        sof       = 1'($urandom);
        corr_in   = 16'($urandom);
        threshold = 16'($urandom);
        @(posedge clock); #1;
        sof       = 1'b0;
    endtask

    task automatic send_pixel(input int val, input bit s, input int thr);
        pix_valid = 1'b1;
        sof       = s;
        corr_in   = 16'(val);
        threshold = s ? 16'(thr) : 16'($urandom);
        @(posedge clock); #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Sends frame_mem in raster order; abort_at >= 0 stops before that pixel.
    task automatic run_frame(input int thr, input int abort_at, input bit push, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (i == abort_at) break;
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            send_pixel(int'(frame_mem[i / IMG_W][i % IMG_W]), i == 0, thr);
        end
        if (push && abort_at < 0) exp_q.push_back(model(thr));
    endtask

    task automatic check_result(input string tag, input res_t e);
        check({tag, "_peak_x"},   int'(peak_x),   e.x);
        check({tag, "_peak_y"},   int'(peak_y),   e.y);
        check({tag, "_peak_val"}, int'(peak_val), e.val);
        check({tag, "_found"},    int'(found),    e.found);
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
        check({tag, "_hit_count"}, int'(hit_count), e.hits);
`endif
    endtask

    // Monitor: every accepted result must match the oldest queued frame.
    initial begin
        res_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && result_valid === 1'b1 && result_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got a result handshake, required none pending");
                end else begin
                    e = exp_q.pop_front();
                    check_result("sb", e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t ea;
        res_t eb;
        int   thr;

        reset_n      = 1'b0;
        pix_valid    = 1'b0;
        sof          = 1'b0;
        corr_in      = 16'd0;
        threshold    = 16'd0;
        result_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        @(negedge clock);
        check("reset_valid",   int'(result_valid), 0);
        check("reset_peak_x",  int'(peak_x), 0);
        check("reset_peak_y",  int'(peak_y), 0);
        check("reset_val",     int'(peak_val), 0);
        check("reset_found",   int'(found), 0);
        check("reset_overrun", int'(overrun), 0);

        // Single peak with latency check.
        fill_zero();
        frame_mem[3][5] = 16'd50;
        @(posedge clock); #1;
        run_frame(10, -1, 1, 0);
        @(negedge clock);
        check("latency_not_early", int'(result_valid), 0);
        @(negedge clock);
        check("single_valid", int'(result_valid), 1);
        check("single_x",     int'(peak_x), 3);
        check("single_y",     int'(peak_y), 1);
        check("single_val",   int'(peak_val), 50);
        check("single_found", int'(found), 1);
        repeat (4) idle_cycle();

        // Tie and window exclusion.
        fill_zero();
        frame_mem[4][1] = 16'd80;
        frame_mem[2][3] = 16'd60;
        frame_mem[4][6] = 16'd60;
        run_frame(10, -1, 1, 1);
        @(negedge clock); @(negedge clock);
        check("tie_x",   int'(peak_x), 1);
        check("tie_y",   int'(peak_y), 0);
        check("tie_val", int'(peak_val), 60);
        repeat (4) idle_cycle();

        // Nothing meets the threshold.
        fill_random(99);
        frame_mem[4][5] = 16'd99;
        run_frame(100, -1, 1, 1);
        @(negedge clock); @(negedge clock);
        check("below_valid", int'(result_valid), 1);
        check("below_found", int'(found), 0);
        check("below_x",     int'(peak_x), 0);
        check("below_y",     int'(peak_y), 0);
        check("below_val",   int'(peak_val), 0);
        repeat (4) idle_cycle();

        // Random frames: wide values, and narrow values to provoke ties.
        for (int f = 0; f < 8; f++) begin
            if (f % 2 == 0) begin
                fill_random(65535);
                thr = $urandom_range(0, 65535);
            end else begin
                fill_random(15);
                thr = $urandom_range(0, 10);
            end
            run_frame(thr, -1, 1, 1);
            repeat ($urandom_range(0, 3)) idle_cycle();
        end

        // Exactly seven candidates, with decoys outside the window.
        fill_zero();
        frame_mem[1][1] = 16'd99;
        frame_mem[0][5] = 16'd99;
        frame_mem[4][6] = 16'd9;
        frame_mem[2][2] = 16'd20;
        frame_mem[2][3] = 16'd20;
        frame_mem[2][7] = 16'd20;
        frame_mem[3][4] = 16'd20;
        frame_mem[5][2] = 16'd20;
        frame_mem[5][5] = 16'd20;
        frame_mem[5][7] = 16'd20;
        run_frame(10, -1, 1, 1);
        @(negedge clock); @(negedge clock);
        check("seven_x",   int'(peak_x), 0);
        check("seven_y",   int'(peak_y), 0);
        check("seven_val", int'(peak_val), 20);
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
        check("seven_hit_count", int'(hit_count), 7);
`endif
        repeat (4) idle_cycle();

        // Mid-frame restart at pixel 20.
        fill_random(65535);
        run_frame($urandom_range(0, 65535), 20, 0, 1);
        fill_random(65535);
        run_frame($urandom_range(0, 40000), -1, 1, 1);
        repeat (4) idle_cycle();

        // Backpressure across two frames.
        check("overrun_before", int'(overrun), 0);
        result_ready = 1'b0;
        fill_random(65535);
        thr = $urandom_range(0, 50000);
        run_frame(thr, -1, 0, 1);
        ea = model(thr);
        @(negedge clock); @(negedge clock);
        check("hold_valid", int'(result_valid), 1);
        check_result("hold_a", ea);
        check("hold_overrun", int'(overrun), 0);
        repeat (20) idle_cycle();
        @(negedge clock);
        check_result("hold_a_late", ea);
        fill_random(65535);
        thr = $urandom_range(0, 50000);
        run_frame(thr, -1, 1, 1);
        eb = model(thr);
        @(negedge clock); @(negedge clock);
        check("ovr_valid", int'(result_valid), 1);
        check("ovr_flag",  int'(overrun), 1);
        check_result("ovr_b", eb);
        @(posedge clock); #1;
        result_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("drop_valid",    int'(result_valid), 0);
        check("overrun_stays", int'(overrun), 1);
        repeat (4) idle_cycle();

        // Reset at pixel 30 of a frame.
        fill_random(65535);
        run_frame(0, 30, 0, 0);
        reset_n   = 1'b0;
        pix_valid = 1'b1;
        corr_in   = 16'($urandom);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        pix_valid = 1'b0;
        @(negedge clock);
        check("rst_valid",   int'(result_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_found",   int'(found), 0);
        check("rst_x",       int'(peak_x), 0);
        check("rst_y",       int'(peak_y), 0);
        check("rst_val",     int'(peak_val), 0);
`ifdef TEMPLATE_PEAK_HITCOUNT_EN
        check("rst_hit_count", int'(hit_count), 0);
`endif
        // A full frame's worth of pixels without sof must be ignored.
        @(posedge clock); #1;
        for (int i = 0; i < NPIX + 2; i++) send_pixel($urandom_range(0, 65535), 0, 0);
        repeat (3) @(negedge clock);
        check("idle_no_result", int'(result_valid), 0);
        fill_random(65535);
        run_frame($urandom_range(0, 30000), -1, 1, 1);

        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
